// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, registered write-first reads,
// an aliased program counter (load/writeback/increment) and a per-bit flags register.
module regfile_mp #(
    parameter int              DATA_W   = 32,
    parameter int              ADDR_W   = 4,
    parameter int              N_RD     = 3,
    parameter int              PC_IDX   = 15,
    parameter int              PC_STEP  = 4,
    parameter int              FLAGS_W  = 4,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [N_RD*ADDR_W-1:0]   rd_sel,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_sel,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_sel,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic [FLAGS_W-1:0]       flags_we,
    input  logic [FLAGS_W-1:0]       flags_in,
    output logic [FLAGS_W-1:0]       flags_out,
    input  logic                     pc_inc,
    input  logic                     pc_load,
    input  logic [DATA_W-1:0]        pc_load_val,
    output logic [DATA_W-1:0]        pc_out
);

    localparam int                  DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0]   PC_SEL     = ADDR_W'(PC_IDX);
    localparam logic [DATA_W-1:0]   ALIGN_MASK = ~DATA_W'(3);

    logic [DATA_W-1:0]       regs_q [DEPTH];
    logic [DATA_W-1:0]       regs_d [DEPTH];
    logic [DATA_W-1:0]       pc_q, pc_d;
    logic [FLAGS_W-1:0]      flags_q, flags_d;
    logic [N_RD*DATA_W-1:0]  rd_q, rd_d;

    logic wa_pc, wb_pc;

    assign wa_pc = wa_en && (wa_sel == PC_SEL);
    assign wb_pc = wb_en && (wb_sel == PC_SEL);

    always_comb begin
        regs_d = regs_q;
        // Port B is applied after port A so it wins on a shared destination
        if (wa_en && !wa_pc) regs_d[wa_sel] = wa_data;
        if (wb_en && !wb_pc) regs_d[wb_sel] = wb_data;

        pc_d = pc_q;
        if (pc_load)     pc_d = pc_load_val & ALIGN_MASK;
        else if (wb_pc)  pc_d = wb_data & ALIGN_MASK;
        else if (wa_pc)  pc_d = wa_data & ALIGN_MASK;
        else if (pc_inc) pc_d = pc_q + DATA_W'(PC_STEP);

        flags_d = (flags_q & ~flags_we) | (flags_in & flags_we);

        // Reads see the post-update state of this edge
        rd_d = '0;
        for (int unsigned k = 0; k < N_RD; k++) begin
            if (rd_sel[k*ADDR_W +: ADDR_W] == PC_SEL)
                rd_d[k*DATA_W +: DATA_W] = pc_d;
            else
                rd_d[k*DATA_W +: DATA_W] = regs_d[rd_sel[k*ADDR_W +: ADDR_W]];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            regs_q  <= '{default: '0};
            pc_q    <= RESET_PC;
            flags_q <= '0;
            rd_q    <= '0;
        end else begin
            regs_q  <= regs_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
            rd_q    <= rd_d;
        end
    end

    assign rd_data   = rd_q;
    assign pc_out    = pc_q;
    assign flags_out = flags_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed plus randomized bench for regfile_mp, checked against an
// architectural model (register array, PC and flags) updated once per edge.
module tb_regfile_mp;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 4;
    localparam int N_RD    = 3;
    localparam int PC_IDX  = 15;
    localparam int PC_STEP = 4;
    localparam int FLAGS_W = 4;
    localparam logic [DATA_W-1:0] RESET_PC = '0;

    logic                    clock;
    logic                    reset_n;
    logic [N_RD*ADDR_W-1:0]  rd_sel;
    logic [N_RD*DATA_W-1:0]  rd_data;
    logic                    wa_en, wb_en;
    logic [ADDR_W-1:0]       wa_sel, wb_sel;
    logic [DATA_W-1:0]       wa_data, wb_data;
    logic [FLAGS_W-1:0]      flags_we, flags_in, flags_out;
    logic                    pc_inc, pc_load;
    logic [DATA_W-1:0]       pc_load_val, pc_out;

    regfile_mp #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD), .PC_IDX(PC_IDX),
        .PC_STEP(PC_STEP), .FLAGS_W(FLAGS_W), .RESET_PC(RESET_PC)
    ) dut (
        .clock(clock), .reset_n(reset_n), .rd_sel(rd_sel), .rd_data(rd_data),
        .wa_en(wa_en), .wa_sel(wa_sel), .wa_data(wa_data),
        .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
        .flags_we(flags_we), .flags_in(flags_in), .flags_out(flags_out),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_val(pc_load_val),
        .pc_out(pc_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0]  m_regs [16];
    logic [DATA_W-1:0]  m_pc;
    logic [FLAGS_W-1:0] m_flags;
    logic [DATA_W-1:0]  m_rd [N_RD];

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] m_read(input int r);
        return (r == PC_IDX) ? m_pc : m_regs[r];
    endfunction

    task automatic model_edge();
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) m_regs[i] = '0;
            m_pc    = RESET_PC;
            m_flags = '0;
            for (int k = 0; k < N_RD; k++) m_rd[k] = '0;
            return;
        end
        if (wa_en && int'(wa_sel) != PC_IDX) m_regs[wa_sel] = wa_data;
        if (wb_en && int'(wb_sel) != PC_IDX) m_regs[wb_sel] = wb_data;
        if (pc_load)                               m_pc = {pc_load_val[DATA_W-1:2], 2'b00};
        else if (wb_en && int'(wb_sel) == PC_IDX)  m_pc = {wb_data[DATA_W-1:2], 2'b00};
        else if (wa_en && int'(wa_sel) == PC_IDX)  m_pc = {wa_data[DATA_W-1:2], 2'b00};
        else if (pc_inc)                           m_pc = m_pc + PC_STEP;
        for (int i = 0; i < FLAGS_W; i++)
            if (flags_we[i]) m_flags[i] = flags_in[i];
        for (int k = 0; k < N_RD; k++)
            m_rd[k] = m_read(int'(rd_sel[k*ADDR_W +: ADDR_W]));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        model_edge();
        for (int k = 0; k < N_RD; k++)
            check($sformatf("rd%0d", k), rd_data[k*DATA_W +: DATA_W], m_rd[k]);
        check("pc", pc_out, m_pc);
        check("flags", DATA_W'(flags_out), DATA_W'(m_flags));
    endtask

    task automatic idle();
        wa_en = 0; wa_sel = '0; wa_data = '0;
        wb_en = 0; wb_sel = '0; wb_data = '0;
        flags_we = '0; flags_in = '0;
        pc_inc = 0; pc_load = 0; pc_load_val = '0;
        rd_sel = '0;
    endtask

    initial begin
        idle();
        reset_n = 0;

        // Reset with a write presented: it must be discarded
        wa_en = 1; wa_sel = 4'd3; wa_data = 32'hDEAD;
        rd_sel = {4'd3, 4'd3, 4'd3};
        tick();
        tick();
        check("rst_pc", pc_out, RESET_PC);
        check("rst_rd0", rd_data[0 +: DATA_W], '0);
        reset_n = 1;
        wa_en = 0;
        tick();
        check("rst_reg3", rd_data[0 +: DATA_W], '0);
        check("rst_flags", DATA_W'(flags_out), '0);

        // Write-first bypass
        idle();
        wa_en = 1; wa_sel = 4'd5; wa_data = 32'h1234;
        rd_sel = {4'd0, 4'd5, 4'd0};
        tick();
        check("bypass_p1", rd_data[1*DATA_W +: DATA_W], 32'h1234);
        wa_en = 0;
        rd_sel = {4'd5, 4'd0, 4'd0};
        tick();
        check("bypass_p2", rd_data[2*DATA_W +: DATA_W], 32'h1234);

        // Write conflict: port B wins on the same destination
        idle();
        wa_en = 1; wa_sel = 4'd7; wa_data = 32'hAAAA;
        wb_en = 1; wb_sel = 4'd7; wb_data = 32'hBBBB;
        rd_sel = {4'd0, 4'd0, 4'd7};
        tick();
        check("conflict_r7", rd_data[0 +: DATA_W], 32'hBBBB);
        wb_sel = 4'd8;
        rd_sel = {4'd0, 4'd8, 4'd7};
        tick();
        check("split_r7", rd_data[0 +: DATA_W], 32'hAAAA);
        check("split_r8", rd_data[1*DATA_W +: DATA_W], 32'hBBBB);

        // PC priority and alignment
        idle();
        pc_inc = 1; pc_load = 1; pc_load_val = 32'h103;
        tick();
        check("pc_load", pc_out, 32'h100);
        pc_load = 0;
        wb_en = 1; wb_sel = 4'd15; wb_data = 32'h2002;
        tick();
        check("pc_wb", pc_out, 32'h2000);
        wb_en = 0;
        tick();
        check("pc_inc", pc_out, 32'h2004);

        // PC wrap
        idle();
        pc_load = 1; pc_load_val = 32'hFFFF_FFFC;
        tick();
        check("pc_top", pc_out, 32'hFFFF_FFFC);
        pc_load = 0; pc_inc = 1;
        rd_sel = {4'd0, 4'd0, 4'd15};
        tick();
        check("pc_wrap", pc_out, 32'h0);
        check("pc_wrap_rd", rd_data[0 +: DATA_W], 32'h0);

        // Flags per-bit enables
        idle();
        flags_we = 4'b1111; flags_in = 4'b0000;
        tick();
        flags_we = 4'b1010; flags_in = 4'b1111;
        tick();
        check("flags_set", DATA_W'(flags_out), 32'hA);
        flags_we = 4'b0000; flags_in = 4'b0000;
        tick();
        check("flags_hold", DATA_W'(flags_out), 32'hA);

        // Randomized traffic, with occasional mid-run resets
        for (int n = 0; n < 400; n++) begin
            reset_n     = ($urandom_range(0, 39) != 0);
            wa_en       = $urandom_range(0, 1) == 1;
            wb_en       = $urandom_range(0, 1) == 1;
            wa_sel      = ($urandom_range(0, 7) == 0) ? 4'd15 : ADDR_W'($urandom_range(0, 15));
            wb_sel      = ($urandom_range(0, 3) == 0) ? wa_sel : ADDR_W'($urandom_range(0, 15));
            wa_data     = $urandom;
            wb_data     = $urandom;
            flags_we    = FLAGS_W'($urandom_range(0, 15));
            flags_in    = FLAGS_W'($urandom_range(0, 15));
            pc_inc      = $urandom_range(0, 1) == 1;
            pc_load     = $urandom_range(0, 7) == 0;
            pc_load_val = $urandom;
            rd_sel      = (N_RD*ADDR_W)'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
